// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes into 32-bit words and buffers them in a show-ahead FIFO.
// Ports: clk/rst_n (sync, active-low), byte_in/byte_valid from the receiver,
// timeout_div (idle flush, 0 = off), clr_ovf, and the word_* valid/ready
// output with level and sticky overflow.
// Build option: UART_RX_WORD_PACKER_BIG_ENDIAN_EN puts byte 0 in [31:24].
module uart_rx_word_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic [15:0]   timeout_div,
  input  logic          clr_ovf,
  input  logic          word_ready,
  output logic [31:0]   word_data,
  output logic [2:0]    word_bytes,
  output logic          word_valid,
  output logic [AW:0]   level,
  output logic          overflow
);

  typedef enum logic {S_EMPTY, S_PARTIAL} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t       state;
  state_t       state_nx;
  logic         valid_d;
  logic         take;
  logic [1:0]   cnt;
  logic [31:0]  shadow;
  logic [31:0]  lane;
  logic [4:0]   sh;
  logic [15:0]  idle;
  logic         tmo;
  logic         push;
  logic         push_full;
  logic [34:0]  push_entry;

  logic [34:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic         pop;
  logic         accept;
  logic         drop;

  // Only the rising edge of the receiver's done level takes a byte.
  assign take = byte_valid & ~valid_d;

`ifdef UART_RX_WORD_PACKER_BIG_ENDIAN_EN
  assign sh = 5'd24 - {cnt, 3'b000};
`else
  assign sh = {cnt, 3'b000};
`endif

  assign lane = {24'd0, byte_in} << sh;

  // A byte arriving in the same cycle as the timeout suppresses the flush.
  assign tmo = (state == S_PARTIAL) && (timeout_div != 16'd0)
               && (idle == timeout_div) && !take;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_EMPTY: begin
        if (take) state_nx = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (take && cnt == 2'd3) state_nx = S_EMPTY;
        else if (tmo)            state_nx = S_EMPTY;
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  always_comb begin
    push_full  = take && (cnt == 2'd3);
    push       = push_full || tmo;
    push_entry = push_full ? {shadow | lane, 3'd4}
                           : {shadow, 1'b0, cnt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_d <= 1'b0;
      cnt     <= 2'd0;
      shadow  <= 32'd0;
      idle    <= 16'd0;
    end else begin
      valid_d <= byte_valid;
      if (push) begin
        cnt    <= 2'd0;
        shadow <= 32'd0;
        idle   <= 16'd0;
      end else if (take) begin
        cnt    <= cnt + 2'd1;
        shadow <= shadow | lane;
        idle   <= 16'd0;
      end else if (state == S_PARTIAL && timeout_div != 16'd0) begin
        idle <= idle + 16'd1;
      end else begin
        idle <= 16'd0;
      end
    end
  end

  assign word_valid = (count != '0);
  assign pop        = word_valid & word_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept     = push & ((count != FULL) | pop);
  assign drop       = push & (count == FULL) & ~pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign level      = count;
  assign word_data  = word_valid ? mem[rd_ptr][34:3] : 32'd0;
  assign word_bytes = word_valid ? mem[rd_ptr][2:0]  : 3'd0;

endmodule
